fpnew_divsqrt_wb_monitor: RTL and testbench

Synthesizable, parametrised protocol monitor for the FPU div/sqrt unit(s). It tracks each channel's start/writeback handshake with a per-channel FSM and latency counter, and raises sticky error flags for four conditions: start/writeback collision, writeback timeout, spurious writeback and start while busy. It also records the worst observed latency. It sits beside the div/sqrt units in the FPU wrapper, drives the debug/status registers, and is bound for formal runs.

---
 rtl/fpnew_divsqrt_wb_monitor.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fpnew_divsqrt_wb_monitor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fpnew_divsqrt_wb_monitor.sv
// -----------------------------------------------------------------------------
// fpnew_divsqrt_wb_monitor
//
// Protocol monitor for the FPU div/sqrt unit(s). Each channel has a two-state
// FSM (IDLE/BUSY) with a latency counter. The monitor raises sticky error flags
// for four conditions:
//   - start/writeback collision
//   - writeback timeout
//   - spurious writeback
//   - start while busy (overlap)
// It also records the worst completed latency.
//
// Parameters:
//   NUM_CH  - number of monitored channels
//   MAX_LAT - maximum legal start-to-writeback latency (cycles, >= 2)
//   LAT_W   - latency counter width (derived)
//   CH_W    - channel index width (derived, min 1)
//
// Ports:
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   op_start_i      per-channel operation start request
//   unit_ready_i    per-channel unit ready
//   wb_valid_i      per-channel writeback valid
//   flush_i         aborts all in-flight tracking
//   clr_i           clears sticky flags and first-error channel
//   busy_o          per-channel FSM in BUSY
//   err_collision_o sticky: accepted start together with writeback
//   err_timeout_o   sticky: no writeback within MAX_LAT cycles
//   err_spurious_o  sticky: writeback while IDLE without a start
//   err_overlap_o   sticky: accepted start while BUSY
//   err_any_o       OR of the four sticky flags
//   err_ch_o        channel of the first error since reset/clear
//   max_lat_o       largest completed latency, saturating at MAX_LAT
//
// Optional feature: define FPNEW_DIVSQRT_MON_ASSERT_EN to compile concurrent
// assertions, one per error condition per channel. Flag behaviour is identical
// with or without the macro.
// -----------------------------------------------------------------------------
module fpnew_divsqrt_wb_monitor #(
    parameter int unsigned NUM_CH  = 1,
    parameter int unsigned MAX_LAT = 32,
    localparam int unsigned LAT_W  = $clog2(MAX_LAT + 1),
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] op_start_i,
    input  logic [NUM_CH-1:0] unit_ready_i,
    input  logic [NUM_CH-1:0] wb_valid_i,
    input  logic              flush_i,
    input  logic              clr_i,
    output logic [NUM_CH-1:0] busy_o,
    output logic              err_collision_o,
    output logic              err_timeout_o,
    output logic              err_spurious_o,
    output logic              err_overlap_o,
    output logic              err_any_o,
    output logic [CH_W-1:0]   err_ch_o,
    output logic [LAT_W-1:0]  max_lat_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    // Lowest-index set bit of a channel vector (0 when none set).
    function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CH_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t           state_r     [NUM_CH];
    state_t           state_nxt_s [NUM_CH];
    logic [LAT_W-1:0] cnt_r       [NUM_CH];
    logic [LAT_W-1:0] cnt_nxt_s   [NUM_CH];

    logic [NUM_CH-1:0] acc_s;
    logic [NUM_CH-1:0] collision_s;
    logic [NUM_CH-1:0] overlap_s;
    logic [NUM_CH-1:0] spurious_s;
    logic [NUM_CH-1:0] timeout_s;
    logic [NUM_CH-1:0] done_s;
    logic [NUM_CH-1:0] any_err_s;

    logic              coll_nxt_s;
    logic              tout_nxt_s;
    logic              spur_nxt_s;
    logic              ovl_nxt_s;
    logic [CH_W-1:0]   ch_nxt_s;
    logic [LAT_W-1:0]  max_nxt_s;

    logic [NUM_CH-1:0] busy_r;
    logic              coll_r;
    logic              tout_r;
    logic              spur_r;
    logic              ovl_r;
    logic              any_r;
    logic [CH_W-1:0]   ch_r;
    logic [LAT_W-1:0]  max_r;

    assign acc_s = op_start_i & unit_ready_i;

    // Per-channel FSM state and latency counter registers.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst_ni) begin
                state_r[c] <= ST_IDLE;
                cnt_r[c]   <= {LAT_W{1'b0}};
            end else begin
                state_r[c] <= state_nxt_s[c];
                cnt_r[c]   <= cnt_nxt_s[c];
            end
        end
    end

    // Per-channel next-state logic; an accepted start always (re)starts tracking.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_nxt_s[c] = state_r[c];
            cnt_nxt_s[c]   = cnt_r[c];
            if (flush_i) begin
                state_nxt_s[c] = ST_IDLE;
                cnt_nxt_s[c]   = {LAT_W{1'b0}};
            end else begin
                case (state_r[c])
                    ST_IDLE: begin
                        if (acc_s[c]) begin
                            state_nxt_s[c] = ST_BUSY;
                            cnt_nxt_s[c]   = LAT_ONE;
                        end else begin
                            state_nxt_s[c] = ST_IDLE;
                            cnt_nxt_s[c]   = {LAT_W{1'b0}};
                        end
                    end
                    ST_BUSY: begin
                        if (acc_s[c]) begin
                            state_nxt_s[c] = ST_BUSY;
                            cnt_nxt_s[c]   = LAT_ONE;
                        end else if (wb_valid_i[c] || (cnt_r[c] == LAT_MAX)) begin
                            state_nxt_s[c] = ST_IDLE;
                            cnt_nxt_s[c]   = {LAT_W{1'b0}};
                        end else begin
                            state_nxt_s[c] = ST_BUSY;
                            cnt_nxt_s[c]   = cnt_r[c] + LAT_ONE;
                        end
                    end
                    default: begin
                        state_nxt_s[c] = ST_IDLE;
                        cnt_nxt_s[c]   = {LAT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Per-channel error and completion events; a flush cycle raises nothing.
    always_comb begin
        collision_s = {NUM_CH{1'b0}};
        overlap_s   = {NUM_CH{1'b0}};
        spurious_s  = {NUM_CH{1'b0}};
        timeout_s   = {NUM_CH{1'b0}};
        done_s      = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            if (!flush_i) begin
                collision_s[c] = acc_s[c] & wb_valid_i[c];
                overlap_s[c]   = (state_r[c] == ST_BUSY) & acc_s[c] & ~wb_valid_i[c];
                spurious_s[c]  = (state_r[c] == ST_IDLE) & wb_valid_i[c] & ~acc_s[c];
                timeout_s[c]   = (state_r[c] == ST_BUSY) & ~acc_s[c] & ~wb_valid_i[c]
                               & (cnt_r[c] == LAT_MAX);
                done_s[c]      = (state_r[c] == ST_BUSY) & ~acc_s[c] & wb_valid_i[c];
            end else begin
                collision_s[c] = 1'b0;
                overlap_s[c]   = 1'b0;
                spurious_s[c]  = 1'b0;
                timeout_s[c]   = 1'b0;
                done_s[c]      = 1'b0;
            end
        end
        any_err_s = collision_s | overlap_s | spurious_s | timeout_s;
    end

    // Sticky flag, first-error channel and worst-latency next values.
    always_comb begin
        max_nxt_s = max_r;
        for (int c = 0; c < NUM_CH; c++) begin
            if (done_s[c] && (cnt_r[c] > max_nxt_s)) begin
                max_nxt_s = cnt_r[c];
            end else begin
                max_nxt_s = max_nxt_s;
            end
        end
        if (max_nxt_s > LAT_MAX) begin
            max_nxt_s = LAT_MAX;
        end else begin
            max_nxt_s = max_nxt_s;
        end

        // Clear and a new error in the same cycle: the new error survives.
        if (clr_i) begin
            coll_nxt_s = |collision_s;
            tout_nxt_s = |timeout_s;
            spur_nxt_s = |spurious_s;
            ovl_nxt_s  = |overlap_s;
            ch_nxt_s   = (|any_err_s) ? first_ch(any_err_s) : {CH_W{1'b0}};
        end else begin
            coll_nxt_s = coll_r | (|collision_s);
            tout_nxt_s = tout_r | (|timeout_s);
            spur_nxt_s = spur_r | (|spurious_s);
            ovl_nxt_s  = ovl_r  | (|overlap_s);
            ch_nxt_s   = (!any_r && (|any_err_s)) ? first_ch(any_err_s) : ch_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_r <= {NUM_CH{1'b0}};
            coll_r <= 1'b0;
            tout_r <= 1'b0;
            spur_r <= 1'b0;
            ovl_r  <= 1'b0;
            any_r  <= 1'b0;
            ch_r   <= {CH_W{1'b0}};
            max_r  <= {LAT_W{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                busy_r[c] <= (state_nxt_s[c] == ST_BUSY);
            end
            coll_r <= coll_nxt_s;
            tout_r <= tout_nxt_s;
            spur_r <= spur_nxt_s;
            ovl_r  <= ovl_nxt_s;
            any_r  <= coll_nxt_s | tout_nxt_s | spur_nxt_s | ovl_nxt_s;
            ch_r   <= ch_nxt_s;
            max_r  <= max_nxt_s;
        end
    end

    assign busy_o          = busy_r;
    assign err_collision_o = coll_r;
    assign err_timeout_o   = tout_r;
    assign err_spurious_o  = spur_r;
    assign err_overlap_o   = ovl_r;
    assign err_any_o       = any_r;
    assign err_ch_o        = ch_r;
    assign max_lat_o       = max_r;

`ifdef FPNEW_DIVSQRT_MON_ASSERT_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_assert
        a_collision: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (!flush_i && acc_s[c]) |-> !wb_valid_i[c]);
        a_overlap: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (!flush_i && (state_r[c] == ST_BUSY) && !wb_valid_i[c]) |-> !acc_s[c]);
        a_spurious: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (!flush_i && (state_r[c] == ST_IDLE) && !acc_s[c]) |-> !wb_valid_i[c]);
        a_timeout: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (!flush_i && (state_r[c] == ST_BUSY) && !acc_s[c] && (cnt_r[c] == LAT_MAX))
            |-> wb_valid_i[c]);
    end
`endif

endmodule

// File: tb/tb_fpnew_divsqrt_wb_monitor.sv
module tb_fpnew_divsqrt_wb_monitor;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned MAX_LAT = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] op_start;
    logic [3:0] unit_ready;
    logic [3:0] wb_valid;
    logic       flush;
    logic       clr;
    logic [3:0] busy;
    logic       err_coll;
    logic       err_tout;
    logic       err_spur;
    logic       err_ovl;
    logic       err_any;
    logic [1:0] err_ch;
    logic [3:0] max_lat;

    fpnew_divsqrt_wb_monitor #(
        .NUM_CH  (NUM_CH),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .op_start_i      (op_start),
        .unit_ready_i    (unit_ready),
        .wb_valid_i      (wb_valid),
        .flush_i         (flush),
        .clr_i           (clr),
        .busy_o          (busy),
        .err_collision_o (err_coll),
        .err_timeout_o   (err_tout),
        .err_spurious_o  (err_spur),
        .err_overlap_o   (err_ovl),
        .err_any_o       (err_any),
        .err_ch_o        (err_ch),
        .max_lat_o       (max_lat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // flags = {overlap, spurious, timeout, collision}
    typedef struct packed {
        logic [3:0] busy;
        logic [3:0] flags;
        logic [1:0] ch;
        logic [3:0] max;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected outputs after the edge ending the next issued cycle.
    logic [3:0] e_busy  = 4'd0;
    logic [3:0] e_flags = 4'd0;
    logic [1:0] e_ch    = 2'd0;
    logic [3:0] e_max   = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per clock, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("busy",    {28'd0, busy}, {28'd0, e.busy});
            chk("flags",   {28'd0, err_ovl, err_spur, err_tout, err_coll}, {28'd0, e.flags});
            chk("err_any", {31'd0, err_any}, {31'd0, |e.flags});
            chk("err_ch",  {30'd0, err_ch}, {30'd0, e.ch});
            chk("max_lat", {28'd0, max_lat}, {28'd0, e.max});
        end
    end

    task automatic cyc(input logic [3:0] st, input logic [3:0] rdy, input logic [3:0] wb,
                       input logic fl, input logic cl, input logic rn);
        op_start   = st;
        unit_ready = rdy;
        wb_valid   = wb;
        flush      = fl;
        clr        = cl;
        rst_n      = rn;
        @(posedge clk);
        exp_q.push_back('{busy: e_busy, flags: e_flags, ch: e_ch, max: e_max});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        op_start = 4'd0; unit_ready = 4'd0; wb_valid = 4'd0;
        flush = 1'b0; clr = 1'b0; rst_n = 1'b0;

        // Reset state
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Normal op on ch0: wb 5 cycles after start -> max_lat 5
        e_busy = 4'b0001; cyc(4'b0001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(4);
        e_busy = 4'b0000; e_max = 4'd5; cyc(4'd0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(1);
        // Start without ready is not accepted
        cyc(4'b0001, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);

        // Reset clears max_lat
        e_max = 4'd0; cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Collision: new op wins, later wb gives latency 3
        e_busy = 4'b0001; e_flags = 4'b0001; e_ch = 2'd0;
        cyc(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(2);
        e_busy = 4'b0000; e_max = 4'd3; cyc(4'd0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        e_flags = 4'b0000; cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

        // Timeout: no wb within MAX_LAT, then a late wb is spurious
        e_busy = 4'b0001; cyc(4'b0001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(7);
        e_busy = 4'b0000; e_flags = 4'b0010; idle(1);
        e_flags = 4'b0110; cyc(4'd0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        e_flags = 4'b0000; cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

        // wb exactly MAX_LAT cycles after start is legal; max_lat reaches MAX_LAT
        e_busy = 4'b0001; cyc(4'b0001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(7);
        e_busy = 4'b0000; e_max = 4'd8; cyc(4'd0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Overlap on ch2 and spurious on ch1 in the same cycle -> err_ch 1
        e_busy = 4'b0100; cyc(4'b0100, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(4'b0100, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        e_flags = 4'b1100; e_ch = 2'd1; cyc(4'b0100, 4'b0100, 4'b0010, 1'b0, 1'b0, 1'b1);
        idle(2);
        e_flags = 4'b0000; e_ch = 2'd0; cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        // Clear together with a new error: set wins, channel captured
        e_flags = 4'b0100; e_ch = 2'd3; cyc(4'd0, 4'd0, 4'b1000, 1'b0, 1'b1, 1'b1);
        // Further error while flags already set keeps the first channel
        cyc(4'd0, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b1);
        e_busy = 4'b0000; cyc(4'd0, 4'd0, 4'b0100, 1'b0, 1'b0, 1'b1);

        // Flush with a start and a wb in the same cycle: no new flags, not busy
        e_busy = 4'b0001; cyc(4'b0001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(2);
        e_busy = 4'b0000; cyc(4'b0010, 4'b0010, 4'b1000, 1'b1, 1'b0, 1'b1);
        idle(1);

        // Reset mid-operation clears everything
        e_busy = 4'b0001; cyc(4'b0001, 4'b0001, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        e_busy = 4'b0000; e_flags = 4'b0000; e_ch = 2'd0; e_max = 4'd0;
        cyc(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
